// File: rtl/button_pkg.sv
// Shared types and width helpers for the front-panel button conditioner.
// Imported by the per-channel conditioner and the array top.
package button_pkg;

  typedef enum logic [1:0] {
    MODE_PRESS   = 2'b00,
    MODE_RELEASE = 2'b01,
    MODE_BOTH    = 2'b10,
    MODE_REPEAT  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HELD   = 2'b01,
    REPEAT = 2'b10
  } rep_state_t;

  localparam int MODE_W = 2;

  // Bits needed to hold values 0..maxVal, never less than one.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: synchroniser, debounce counter, edge detect and the
// hold-to-repeat state machine, producing a registered level and pulse.
module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 3
) (
  input  logic  Clk,
  input  logic  nRst,
  input  logic  Pin,
  input  mode_t Mode,
  output logic  Level,
  output logic  Pulse
);

  localparam logic            IDLE_PIN    = (ACTIVE_LOW != 0);
  localparam int              DB_W        = cntWidth(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int              REP_W       = cntWidth(maxOf(REPEAT_DELAY - 1, REPEAT_PERIOD - 1));
  localparam logic [REP_W-1:0] DELAY_LOAD  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LOAD = REP_W'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] syncReg;
  logic                   pressed;

  logic                   levelReg, levelNext;
  logic [DB_W-1:0]        dbCntReg, dbCntNext;
  logic                   commit, rise, fall;

  rep_state_t             stateReg, stateNext;
  logic [REP_W-1:0]       repCntReg, repCntNext;
  logic                   repPulse, edgePulse;
  logic                   pulseReg, pulseNext;

  // Sync flops rest at the idle pin level so reset never looks like a press.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      syncReg <= {SYNC_STAGES{IDLE_PIN}};
    end else begin
      syncReg <= {syncReg[SYNC_STAGES-2:0], Pin};
    end
  end

  assign pressed = (ACTIVE_LOW != 0) ? ~syncReg[SYNC_STAGES-1] : syncReg[SYNC_STAGES-1];

  always_comb begin
    commit    = 1'b0;
    dbCntNext = '0;
    levelNext = levelReg;
    if (pressed != levelReg) begin
      if (dbCntReg == DB_LAST) begin
        commit    = 1'b1;
        levelNext = ~levelReg;
      end else begin
        dbCntNext = dbCntReg + DB_W'(1);
      end
    end
  end

  assign rise = commit & ~levelReg;
  assign fall = commit &  levelReg;

  always_comb begin
    edgePulse = 1'b0;
    case (Mode)
      MODE_PRESS:   edgePulse = rise;
      MODE_RELEASE: edgePulse = fall;
      MODE_BOTH:    edgePulse = rise | fall;
      MODE_REPEAT:  edgePulse = rise;
      default:      edgePulse = 1'b0;
    endcase
  end

  // A committing fall wins over a repeat that would land in the same cycle.
  always_comb begin
    stateNext  = stateReg;
    repCntNext = repCntReg;
    repPulse   = 1'b0;
    if ((Mode != MODE_REPEAT) || fall) begin
      stateNext  = IDLE;
      repCntNext = '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (rise) begin
            stateNext  = HELD;
            repCntNext = DELAY_LOAD;
          end
        end
        HELD, REPEAT: begin
          if (repCntReg == '0) begin
            repPulse   = 1'b1;
            stateNext  = REPEAT;
            repCntNext = PERIOD_LOAD;
          end else begin
            repCntNext = repCntReg - REP_W'(1);
          end
        end
        default: begin
          stateNext  = IDLE;
          repCntNext = '0;
        end
      endcase
    end
  end

  assign pulseNext = edgePulse | repPulse;

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      levelReg  <= 1'b0;
      dbCntReg  <= '0;
      stateReg  <= IDLE;
      repCntReg <= '0;
      pulseReg  <= 1'b0;
    end else begin
      levelReg  <= levelNext;
      dbCntReg  <= dbCntNext;
      stateReg  <= stateNext;
      repCntReg <= repCntNext;
      pulseReg  <= pulseNext;
    end
  end

  assign Level = levelReg;
  assign Pulse = pulseReg;

endmodule

// File: rtl/button_pulse_array.sv
// Front-panel button conditioner: N_CH independent channels sharing one
// pulse mode, plus a registered "any button event" flag.
module button_pulse_array
  import button_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 3
) (
  input  logic              Clk,
  input  logic              nRst,
  input  logic [N_CH-1:0]   SignalIn,
  input  logic [MODE_W-1:0] Mode,
  output logic [N_CH-1:0]   Level,
  output logic [N_CH-1:0]   PulseOut,
  output logic              AnyPulse
);

  mode_t modeSel;
  logic  anyPulseReg;

  assign modeSel = mode_t'(Mode);

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      button_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) uChannel (
        .Clk   (Clk),
        .nRst  (nRst),
        .Pin   (SignalIn[gi]),
        .Mode  (modeSel),
        .Level (Level[gi]),
        .Pulse (PulseOut[gi])
      );
    end
  endgenerate

  // Registered from the already-registered pulses, so it trails by one cycle.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      anyPulseReg <= 1'b0;
    end else begin
      anyPulseReg <= |PulseOut;
    end
  end

  assign AnyPulse = anyPulseReg;

endmodule

// File: tb/tb_button_pulse_array.sv
// Directed bench: expected level toggles and pulses are queued when pins are
// driven and checked against the outputs on every falling clock edge.
module tb_button_pulse_array;

  localparam int N   = 4;
  localparam int LAT = 6;

  logic         Clk = 1'b0;
  logic         nRst;
  logic [N-1:0] SignalIn;
  logic [1:0]   Mode;
  logic [N-1:0] Level;
  logic [N-1:0] PulseOut;
  logic         AnyPulse;

  typedef struct {
    int           cyc;
    logic [N-1:0] pulse;
    logic [N-1:0] lvl;
  } ev_t;

  ev_t          sb[$];
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  logic [N-1:0] expLevel = '0;
  logic [N-1:0] prevExpPulse = '0;

  button_pulse_array #(
    .N_CH            (N),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .ACTIVE_LOW      (1),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (3)
  ) dut (
    .Clk      (Clk),
    .nRst     (nRst),
    .SignalIn (SignalIn),
    .Mode     (Mode),
    .Level    (Level),
    .PulseOut (PulseOut),
    .AnyPulse (AnyPulse)
  );

  always #5 Clk = ~Clk;

  task automatic sbPush(input int at, input logic [N-1:0] p, input logic [N-1:0] l);
    ev_t e;
    int  i;
    e.cyc   = at;
    e.pulse = p;
    e.lvl   = l;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > at) i--;
    sb.insert(i, e);
  endtask

  task automatic checkCycle();
    logic [N-1:0] expPulse;
    logic [N-1:0] toggles;
    logic         expAny;
    expPulse = '0;
    toggles  = '0;
    expAny   = |prevExpPulse;
    if (!nRst) begin
      sb.delete();
      expLevel = '0;
      expAny   = 1'b0;
    end else begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        expPulse |= sb[0].pulse;
        toggles  |= sb[0].lvl;
        sb.delete(0);
      end
    end
    expLevel ^= toggles;
    total++;
    assert (Level === expLevel) else begin
      bad++;
      $error("FAIL level cyc=%0d observed=%b expected=%b", cyc, Level, expLevel);
    end
    total++;
    assert (PulseOut === expPulse) else begin
      bad++;
      $error("FAIL pulse cyc=%0d observed=%b expected=%b", cyc, PulseOut, expPulse);
    end
    total++;
    assert (AnyPulse === expAny) else begin
      bad++;
      $error("FAIL anypulse cyc=%0d observed=%b expected=%b", cyc, AnyPulse, expAny);
    end
    $display("cyc=%0d nRst=%b mode=%b pins=%b level=%b pulse=%b any=%b",
             cyc, nRst, Mode, SignalIn, Level, PulseOut, AnyPulse);
    prevExpPulse = expPulse;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      cyc++;
      @(negedge Clk);
      checkCycle();
    end
  endtask

  task automatic checkZero(input string tag);
    total++;
    assert (Level === '0 && PulseOut === '0 && AnyPulse === 1'b0) else begin
      bad++;
      $error("FAIL %s observed=%b/%b/%b expected=0000/0000/0", tag, Level, PulseOut, AnyPulse);
    end
  endtask

  initial begin
    int t;
    nRst     = 1'b0;
    SignalIn = '1;
    Mode     = 2'b00;
    step(3);
    checkZero("reset_state");
    nRst = 1'b1;
    step(4);

    // Press mode: ch0 held 20 cycles
    Mode = 2'b00;
    SignalIn[0] = 1'b0;
    sbPush(cyc + LAT, 4'b0001, 4'b0001);
    step(20);
    SignalIn[0] = 1'b1;
    sbPush(cyc + LAT, 4'b0000, 4'b0001);
    step(12);

    // ch1: 3-cycle glitch rejected, 4-cycle press accepted
    SignalIn[1] = 1'b0;
    step(3);
    SignalIn[1] = 1'b1;
    step(10);
    SignalIn[1] = 1'b0;
    sbPush(cyc + LAT, 4'b0010, 4'b0010);
    sbPush(cyc + LAT + 4, 4'b0000, 4'b0010);
    step(4);
    SignalIn[1] = 1'b1;
    step(12);

    // Release mode: ch2
    Mode = 2'b01;
    SignalIn[2] = 1'b0;
    sbPush(cyc + LAT, 4'b0000, 4'b0100);
    step(15);
    SignalIn[2] = 1'b1;
    sbPush(cyc + LAT, 4'b0100, 4'b0100);
    step(12);

    // Repeat mode: ch0, Level falls 19 cycles after the press pulse
    Mode = 2'b11;
    SignalIn[0] = 1'b0;
    t = cyc + LAT;
    sbPush(t,      4'b0001, 4'b0001);
    sbPush(t + 8,  4'b0001, 4'b0000);
    sbPush(t + 11, 4'b0001, 4'b0000);
    sbPush(t + 14, 4'b0001, 4'b0000);
    sbPush(t + 17, 4'b0001, 4'b0000);
    step(19);
    SignalIn[0] = 1'b1;
    sbPush(t + 19, 4'b0000, 4'b0001);
    step(12);

    // Both-edge mode: ch0 and ch3 together
    Mode = 2'b10;
    SignalIn[0] = 1'b0;
    SignalIn[3] = 1'b0;
    sbPush(cyc + LAT, 4'b1001, 4'b1001);
    step(10);
    SignalIn[0] = 1'b1;
    SignalIn[3] = 1'b1;
    sbPush(cyc + LAT, 4'b1001, 4'b1001);
    step(12);

    // Repeat mode with reset mid-repeat, ch0 held throughout
    Mode = 2'b11;
    SignalIn[0] = 1'b0;
    t = cyc + LAT;
    sbPush(t,      4'b0001, 4'b0001);
    sbPush(t + 8,  4'b0001, 4'b0000);
    sbPush(t + 11, 4'b0001, 4'b0000);
    step(18);
    nRst = 1'b0;
    #1;
    checkZero("async_reset");
    step(3);
    nRst = 1'b1;
    t = cyc + LAT;
    sbPush(t,      4'b0001, 4'b0001);
    sbPush(t + 8,  4'b0001, 4'b0000);
    sbPush(t + 11, 4'b0001, 4'b0000);
    step(12);
    SignalIn[0] = 1'b1;
    sbPush(cyc + LAT, 4'b0000, 4'b0001);
    step(14);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
